multi_cycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the RISC datapath: fetch, decode, execute, memory access and write-back.
- Latches the fetched instruction into an instruction register (IR) and drives the datapath strobes: reg_write, mem_read, mem_write, alu_src, pc_write, pc_src and alu_op.
- Keeps architectural carry/zero flags for conditional R-type instructions.
- Sits between instruction memory and the datapath as the only source of datapath control.

---
 rtl/multi_cycle_ctrl.sv | 107 ++++++++++
 tb/tb_multi_cycle_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle FSM sequencing fetch/decode/exec/mem/wb for the RISC datapath
module multi_cycle_ctrl #(
  parameter logic [3:0] HALT_OP       = 4'b1111,
  parameter int         FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        proc_rst,
  input  logic [15:0] instr_in,
  input  logic        imem_ready,
  input  logic        Carry,
  input  logic        Zero,
  output logic        imem_req,
  output logic [15:0] instruction,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        pc_write,
  output logic        pc_src,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic        illegal,
  output logic        fetch_err,
  output logic [2:0]  state_out
);
  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  state_t          r_state, w_next;
  logic [15:0]     r_ir;
  logic [CW-1:0]   r_cnt;
  logic            r_cflag, r_zflag, r_illegal, r_fetch_err;
  logic [3:0]      w_op;
  logic            w_add, w_adi, w_nand, w_lw, w_sw, w_beq, w_halt;
  logic            w_legal, w_cond_ok, w_timeout, w_fetch_hit, w_br_taken, w_alu_phase;
  assign w_op        = r_ir[15:12];
  assign w_add       = w_op == 4'b0000;
  assign w_adi       = w_op == 4'b0001;
  assign w_nand      = w_op == 4'b0010;
  assign w_sw        = w_op == 4'b1001;
  assign w_lw        = w_op == 4'b1010;
  assign w_beq       = w_op == 4'b1100;
  assign w_halt      = w_op == HALT_OP;
  assign w_legal     = w_add | w_adi | w_nand | w_sw | w_lw | w_beq | w_halt;
  // R-type condition field: always / zero set / carry set / never
  assign w_cond_ok   = r_ir[1] ? (r_ir[0] ? 1'b0 : r_cflag) : (r_ir[0] ? r_zflag : 1'b1);
  assign w_timeout   = r_cnt == CW'(FETCH_TIMEOUT - 1);
  assign w_fetch_hit = r_state == S_FETCH && imem_ready;
  assign w_br_taken  = r_state == S_EXEC && w_beq && Zero;
  assign w_alu_phase = r_state == S_EXEC || r_state == S_MEM || r_state == S_WB;
  // state register
  always_ff @(posedge clk or negedge proc_rst)
    if (!proc_rst) r_state <= S_FETCH;
    else           r_state <= w_next;
  // next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = imem_ready ? S_DECODE : (w_timeout ? S_HALT : S_FETCH);
      S_DECODE: w_next = w_halt ? S_HALT
                       : (!w_legal || ((w_add || w_nand) && !w_cond_ok)) ? S_FETCH : S_EXEC;
      S_EXEC:   w_next = (w_lw || w_sw) ? S_MEM : (w_beq ? S_FETCH : S_WB);
      S_MEM:    w_next = w_lw ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end
  // IR, architectural flags, sticky error flags and fetch-wait counter
  always_ff @(posedge clk or negedge proc_rst)
    if (!proc_rst) begin
      r_ir        <= '0;
      r_cnt       <= '0;
      r_cflag     <= 1'b0;
      r_zflag     <= 1'b0;
      r_illegal   <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_fetch_hit) r_ir <= instr_in;
      r_cnt <= (r_state == S_FETCH && !imem_ready && !w_timeout) ? r_cnt + CW'(1) : '0;
      if (r_state == S_FETCH && !imem_ready && w_timeout) r_fetch_err <= 1'b1;
      if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
      if (r_state == S_EXEC && (w_add || w_adi)) r_cflag <= Carry;
      if (r_state == S_EXEC && (w_add || w_adi || w_nand)) r_zflag <= Zero;
    end
  // datapath strobes, forced low while reset is held
  always_comb begin
    imem_req  = proc_rst && r_state == S_FETCH;
    pc_write  = proc_rst && (w_fetch_hit || w_br_taken);
    pc_src    = proc_rst && w_br_taken;
    alu_src   = proc_rst && w_alu_phase && (w_adi || w_lw || w_sw);
    alu_op    = (proc_rst && w_alu_phase) ? (w_nand ? 3'b010 : (w_beq ? 3'b001 : 3'b000)) : 3'b000;
    mem_read  = proc_rst && r_state == S_MEM && w_lw;
    mem_write = proc_rst && r_state == S_MEM && w_sw;
    reg_write = proc_rst && r_state == S_WB;
    halted    = r_state == S_HALT;
  end
  assign instruction = r_ir;
  assign illegal     = r_illegal;
  assign fetch_err   = r_fetch_err;
  assign state_out   = r_state;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed checks of the multi-cycle control FSM
module tb_multi_cycle_ctrl;
  logic        clk = 1'b0;
  logic        proc_rst;
  logic [15:0] instr_in;
  logic        imem_ready, Carry, Zero;
  logic        imem_req, reg_write, mem_read, mem_write, alu_src, pc_write, pc_src;
  logic        halted, illegal, fetch_err;
  logic [15:0] instruction;
  logic [2:0]  alu_op, state_out;
  int          n_chk = 0;
  int          n_err = 0;
  int          ncyc;
  logic [29:0] seq;
  logic [9:0]  rw, mr, mw, pw, ps;
  logic [2:0]  ex_aop;
  logic        ex_src;
  multi_cycle_ctrl dut (
    .clk(clk), .proc_rst(proc_rst), .instr_in(instr_in), .imem_ready(imem_ready),
    .Carry(Carry), .Zero(Zero), .imem_req(imem_req), .instruction(instruction),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .halted(halted),
    .illegal(illegal), .fetch_err(fetch_err), .state_out(state_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic rec();
    check("excl", 32'(reg_write + mem_read + mem_write) <= 1, 1);
    check("pw_state", pc_write && !(state_out == 3'd0 || state_out == 3'd2), 0);
    seq[3*ncyc +: 3] = state_out;
    rw[ncyc] = reg_write;
    mr[ncyc] = mem_read;
    mw[ncyc] = mem_write;
    pw[ncyc] = pc_write;
    ps[ncyc] = pc_src;
    if (state_out == 3'd2) begin
      ex_aop = alu_op;
      ex_src = alu_src;
    end
    ncyc++;
  endtask
  task automatic run(input string tag, input logic [15:0] ins, input logic c, z,
                     input int exp_n, input logic [29:0] exp_seq, input logic [9:0] exp_rw);
    seq = '0; rw = '0; mr = '0; mw = '0; pw = '0; ps = '0; ex_aop = '0; ex_src = 1'b0; ncyc = 0;
    instr_in = ins; imem_ready = 1'b1; Carry = c; Zero = z;
    #1;
    rec();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      imem_ready = 1'b0;
      #1;
      if (state_out == 3'd0) break;
      rec();
    end
    check({tag, "_back"}, state_out, 0);
    check({tag, "_n"}, ncyc, exp_n);
    check({tag, "_seq"}, seq, exp_seq);
    check({tag, "_rw"}, rw, exp_rw);
  endtask
  initial begin
    proc_rst = 1'b0; instr_in = 16'h0298; imem_ready = 1'b1; Carry = 1'b0; Zero = 1'b0;
    #12;
    check("rst_state", state_out, 0);
    check("rst_ir", instruction, 0);
    check("rst_req", imem_req, 0);
    check("rst_pw", pc_write, 0);
    check("rst_flags", {halted, illegal, fetch_err}, 0);
    @(posedge clk); #2;
    proc_rst = 1'b1;
    run("add", 16'h0298, 1, 0, 4, 'o4210, 'b1000);
    check("add_pw", pw, 'b0001);
    check("add_ps", ps, 0);
    check("add_mem", {mr, mw}, 0);
    check("add_aop", ex_aop, 0);
    check("add_src", ex_src, 0);
    check("add_ir", instruction, 16'h0298);
    run("cc_take", 16'h029A, 0, 0, 4, 'o4210, 'b1000);
    run("cc_skip", 16'h029A, 0, 0, 2, 'o10, 0);
    check("skip_pw", pw, 'b01);
    run("lw", 16'hA285, 0, 0, 5, 'o43210, 'b10000);
    check("lw_mr", mr, 'b01000);
    check("lw_mw", mw, 0);
    check("lw_src", ex_src, 1);
    check("lw_aop", ex_aop, 0);
    run("sw", 16'h9285, 0, 0, 4, 'o3210, 0);
    check("sw_mw", mw, 'b1000);
    check("sw_mr", mr, 0);
    check("sw_src", ex_src, 1);
    run("beq_t", 16'hC285, 1, 1, 3, 'o210, 0);
    check("beq_t_pw", pw, 'b101);
    check("beq_t_ps", ps, 'b100);
    check("beq_aop", ex_aop, 3'b001);
    run("z_kept0", 16'h0299, 0, 0, 2, 'o10, 0);
    run("c_kept0", 16'h029A, 0, 0, 2, 'o10, 0);
    run("add_set", 16'h0298, 1, 1, 4, 'o4210, 'b1000);
    run("beq_n", 16'hC285, 0, 0, 3, 'o210, 0);
    check("beq_n_pw", pw, 'b001);
    check("beq_n_ps", ps, 0);
    run("z_kept1", 16'h0299, 1, 1, 4, 'o4210, 'b1000);
    run("c_kept1", 16'h029A, 1, 1, 4, 'o4210, 'b1000);
    run("nand", 16'h2298, 0, 0, 4, 'o4210, 'b1000);
    check("nand_aop", ex_aop, 3'b010);
    run("nand_z", 16'h0299, 0, 0, 2, 'o10, 0);
    run("nand_c", 16'h029A, 1, 0, 4, 'o4210, 'b1000);
    run("never", 16'h029B, 0, 0, 2, 'o10, 0);
    check("ill_pre", illegal, 0);
    run("ill", 16'h7000, 0, 0, 2, 'o10, 0);
    check("ill_set", illegal, 1);
    run("post_ill", 16'h0298, 0, 0, 4, 'o4210, 'b1000);
    check("ill_sticky", illegal, 1);
    instr_in = 16'hA285; imem_ready = 1'b1;
    @(posedge clk); #1; imem_ready = 1'b0; #1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("mr_state", state_out, 3);
    check("mr_on", mem_read, 1);
    proc_rst = 1'b0;
    #1;
    check("mr_drop", mem_read, 0);
    check("mr_rst_state", state_out, 0);
    check("mr_rst_ir", instruction, 0);
    check("mr_rst_ill", illegal, 0);
    @(posedge clk); #2;
    check("mr_no_rw", reg_write, 0);
    check("mr_hold_state", state_out, 0);
    proc_rst = 1'b1;
    begin
      int n = 0;
      while (!halted && n < 40) begin
        @(posedge clk); #2;
        n++;
      end
      check("to_cycles", n, 16);
    end
    check("to_err", fetch_err, 1);
    check("to_state", state_out, 5);
    check("to_req", imem_req, 0);
    proc_rst = 1'b0;
    #1;
    check("rst2_flags", {halted, fetch_err}, 0);
    @(posedge clk); #2;
    proc_rst = 1'b1;
    instr_in = 16'hF000; imem_ready = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("halt_on", halted, 1);
    check("halt_state", state_out, 5);
    repeat (5) @(posedge clk);
    #2;
    check("halt_stay", state_out, 5);
    check("halt_strobes", {imem_req, pc_write, reg_write, mem_read, mem_write}, 0);
    check("halt_ir", instruction, 16'hF000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
